rs232_tx: RTL
=============

# rs232_tx

Serial transmit engine for the RS232 memory link: accepts bytes from the memory-side logic, buffers them in a small FIFO and serializes each onto `tx` as one frame: start bit, 8 data bits MSB first, odd parity bit, stop bit. Bit timing comes from the shared `rs232_clk_gen` enable (one pulse per bit period, 9600 baud on the 100 MHz system clock). It is the transmit counterpart of the controller's receive path and uses the same frame format.

## Interface
- `FIFO_DEPTH`, 4: byte entries buffered ahead of the serializer; must be a power of 2, ≥2.
- `clk` input 1: system clock, 100 MHz; all logic on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clk_rs232_en` input 1: one-`clk`-wide bit-period strobe from `rs232_clk_gen`.
- `send_word` input 1: write strobe; `data_rs232_out` is pushed on every cycle where this is high and `ready` is high.
- `data_rs232_out` input 8: byte to transmit.
- `ready` output 1: FIFO not full.
- `busy` output 1: a frame is on the line or the FIFO is non-empty.
- `overflow` output 1: sticky; set when `send_word` is high while `ready` is low; cleared only by `rst`.
- `tx` output 1: serial line, idle high.

## Operation
- Reset values: `tx`=1, `ready`=1, `busy`=0, `overflow`=0, FIFO empty, FSM in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. On `clk_rs232_en` with FIFO non-empty, pop the head byte into the shift register, compute parity, go to START, and drive `tx`=0.
- START: on strobe, go to DATA, drive bit 7, bit counter=7.
- DATA: on each strobe, drive the next bit (7 down to 0). After bit 0 has been held for one period, go to PARITY.
- PARITY: drive `~^byte`, so the 9 bits data+parity hold an odd number of ones. On strobe, go to STOP.
- STOP: drive `tx`=1 for one period. At the closing strobe:
  - FIFO non-empty: pop, go directly to START with no idle gap between frames.
  - Otherwise: go to IDLE.
- A frame occupies exactly 11 bit periods. Every `tx` transition coincides with a `clk_rs232_en` cycle.
- FIFO:
  - Push occurs when `send_word` is high and the FIFO is not full. A push while full is dropped and sets `overflow`.
  - Pop only on a frame-start strobe.
  - Simultaneous push and pop on a full FIFO: the pop frees a slot but the push is still refused (`ready` is evaluated before the edge).
  - Simultaneous push and pop on an empty FIFO is impossible, since a pop requires non-empty.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·DEPTH. Full when the MSBs differ and the rest are equal.
- Bytes already popped are never altered by later pushes.

## Timing
- Push-to-line latency from idle: the start bit begins on the first `clk_rs232_en` strictly after the push cycle. This is 1 to 10417 clocks, depending on strobe phase.
- `tx` is a registered output; it changes in the cycle after the strobe is sampled.
- `ready` and `overflow` are registered. `ready` falls in the cycle after the push that fills the FIFO.
- `busy` is registered and falls in the cycle after the STOP strobe of the last queued byte.
- `rst` mid-frame forces `tx`=1 immediately (asynchronously), empties the FIFO, and leaves no partial frame resumed after release.
- `clk_rs232_en` held high continuously is legal and advances one bit per clock (used for fast simulation).

## Structure
- Shared header `rs232_defs.vh`, also used by `rs232_ctrl`:
  - FSM state encodings.
  - `RS232_DATA_BITS`=8.
  - `RS232_FRAME_BITS`=11.
  - Parity-odd constant.
  - `RS232_BIT_NS`=104170.
- Sub-module `rs232_tx_fifo` holds the synchronous-write, registered-read byte FIFO with full/empty logic and is parameterized by `FIFO_DEPTH`.
- `rs232_tx` contains the FSM, shift register, bit counter and parity.

## Test plan
- Single byte 0x0A pushed in idle -> `tx` = 0 | 0,0,0,0,1,0,1,0 | 1 | 1, each bit 104170 ns. `busy` is high from the push until the stop bit ends.
- Single byte 0x0D -> `tx` = 0 | 0,0,0,0,1,1,0,1 | 0 | 1, with parity 0 since the data holds three ones.
- Three bytes 0x55, 0xFF, 0x00 pushed back-to-back -> three contiguous 11-bit frames with no idle gap. Parity bits are 1, 1, 1.
- With `clk_rs232_en` tied high, push 6 bytes while the first frame is active:
  - 5 bytes are accepted (1 in the shifter, 4 queued).
  - The 6th is dropped.
  - `ready`=0 and `overflow`=1 after the 6th push.
  - Exactly 5 frames are emitted, in order.
- Assert `rst` during bit 4 of a 0xA5 frame -> `tx`=1 within the same cycle. After release: `busy`=0, `ready`=1, `overflow`=0, and no further frame is emitted.
- FIFO wrap: push and drain 10 bytes, values 0x01 to 0x0A, in bursts of 3 -> all bytes are transmitted in order and no spurious full/empty occurs at the pointer wrap.

Source files
------------

// File: rtl/rs232_tx_pkg.sv
// Shared RS232 frame definitions: FSM encoding, frame geometry and the parity rule.
// The receive side of the controller uses the same frame format.
package rs232_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int   RS232_DATA_BITS  = 8;
    localparam int   RS232_FRAME_BITS = 11;
    localparam logic RS232_PARITY_ODD = 1'b1;

    // Parity bit that makes data plus parity hold an odd number of ones.
    function automatic logic parity_bit(input logic [RS232_DATA_BITS-1:0] d);
        return RS232_PARITY_ODD ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/rs232_tx_fifo.sv
// Byte FIFO ahead of the serializer: synchronous write, head read straight from the
// storage registers, extra pointer MSB distinguishes full from empty.
module rs232_tx_fifo
    import rs232_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [RS232_DATA_BITS-1:0] wdata,
    output logic [RS232_DATA_BITS-1:0] head,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]                  wr_ptr;
    logic [AW:0]                  rd_ptr;
    logic [RS232_DATA_BITS-1:0]   mem [DEPTH];

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/rs232_tx.sv
// RS232 transmit engine: buffers bytes and sends start, 8 data bits MSB first,
// odd parity and stop, one bit per clk_rs232_en strobe.
module rs232_tx
    import rs232_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_rs232_en,
    input  logic                       send_word,
    input  logic [RS232_DATA_BITS-1:0] data_rs232_out,
    output logic                       ready,
    output logic                       busy,
    output logic                       overflow,
    output logic                       tx
);
    tx_state_t                  state;
    logic [RS232_DATA_BITS-1:0] shreg;
    logic [2:0]                 bit_cnt;
    logic                       par;
    logic [RS232_DATA_BITS-1:0] head;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;

    assign ready = ~full;
    assign push  = send_word & ready;
    // A new frame may only begin from IDLE or at the closing strobe of STOP.
    assign pop   = clk_rs232_en & ~empty & ((state == ST_IDLE) | (state == ST_STOP));

    rs232_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (data_rs232_out),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            par      <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= overflow | (send_word & ~ready);
            // Busy stays up unless the line is about to go idle with nothing queued.
            busy     <= push | ~empty |
                        ((state != ST_IDLE) & ~((state == ST_STOP) & clk_rs232_en));
            if (clk_rs232_en) begin
                case (state)
                    ST_IDLE, ST_STOP: begin
                        if (!empty) begin
                            shreg <= head;
                            par   <= parity_bit(head);
                            tx    <= 1'b0;
                            state <= ST_START;
                        end else begin
                            tx    <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    ST_START: begin
                        tx      <= shreg[7];
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= 3'd7;
                        state   <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_cnt == 3'd0) begin
                            tx    <= par;
                            state <= ST_PARITY;
                        end else begin
                            tx      <= shreg[7];
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt - 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        tx    <= 1'b1;
                        state <= ST_STOP;
                    end
                    default: begin
                        tx    <= 1'b1;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
